// File: rtl/parallel_in_serial_out_piso_param.sv
// rtl/parallel_in_serial_out_piso_param.sv - parameterised parallel-in serial-out serialiser
// Purpose: accepts a DATA_WIDTH word over a valid/ready handshake and shifts it out
//   one bit per enabled cycle, MSB or LSB first, with start/done frame strobes.
//   Back-to-back frames are supported by accepting the next word on the final frame cycle.
// Optional feature macro: PISO_PARITY_EN appends one even-parity bit after the data bits.
// Ports:
//   Clk_In            - clock, rising edge
//   Reset_N_In        - asynchronous active-low reset
//   Enable_In         - global advance qualifier; low freezes all state
//   Load_Valid_In     - a parallel word is offered
//   Parallel_Data_In  - word to serialise
//   Load_Ready_Out    - word is accepted this cycle if Load_Valid_In is high
//   Serial_Data_Out   - current serial bit
//   Serial_Valid_Out  - Serial_Data_Out carries a frame bit
//   Frame_Start_Out   - strobe on the first bit of a frame
//   Frame_Done_Out    - strobe on the final cycle of a frame
//   Busy_Out          - state is not IDLE
module parallel_in_serial_out_piso_param #(
  parameter int DATA_WIDTH = 32,
  parameter int MSB_FIRST  = 1
) (
  input  logic                  Clk_In,
  input  logic                  Reset_N_In,
  input  logic                  Enable_In,
  input  logic                  Load_Valid_In,
  input  logic [DATA_WIDTH-1:0] Parallel_Data_In,
  output logic                  Load_Ready_Out,
  output logic                  Serial_Data_Out,
  output logic                  Serial_Valid_Out,
  output logic                  Frame_Start_Out,
  output logic                  Frame_Done_Out,
  output logic                  Busy_Out
);

  localparam int            CW       = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(DATA_WIDTH - 1);

`ifdef PISO_PARITY_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PARITY = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1} state_t;
`endif

  state_t                  state, state_next;
  logic [DATA_WIDTH-1:0]   shift_reg, shift_next, shifted;
  logic [CW-1:0]           bit_cnt, cnt_next;
  logic                    rst_done;
  logic                    final_cycle;
  logic                    load_accept;
  logic                    head_bit;
`ifdef PISO_PARITY_EN
  logic                    parity_acc, parity_next;
`endif

  // The bit on the line is always at the head end of the shift register.
  assign head_bit = (MSB_FIRST != 0) ? shift_reg[DATA_WIDTH-1] : shift_reg[0];
  assign shifted  = (MSB_FIRST != 0) ? {shift_reg[DATA_WIDTH-2:0], 1'b0}
                                     : {1'b0, shift_reg[DATA_WIDTH-1:1]};

`ifdef PISO_PARITY_EN
  assign final_cycle = (state == PARITY);
`else
  assign final_cycle = (state == SHIFT) && (bit_cnt == LAST_CNT);
`endif

  // rst_done keeps ready low while reset is held and until the first edge after release.
  assign Load_Ready_Out   = Enable_In && rst_done && ((state == IDLE) || final_cycle);
  assign load_accept      = Load_Valid_In && Load_Ready_Out;
  assign Serial_Valid_Out = Enable_In && (state != IDLE);
  assign Frame_Start_Out  = Enable_In && (state == SHIFT) && (bit_cnt == '0);
  assign Frame_Done_Out   = Enable_In && final_cycle;
  assign Busy_Out         = (state != IDLE);

  // Depends only on held state, so the value naturally holds while Enable_In is low.
  always_comb begin
    Serial_Data_Out = 1'b0;
    case (state)
      SHIFT:   Serial_Data_Out = head_bit;
`ifdef PISO_PARITY_EN
      PARITY:  Serial_Data_Out = parity_acc;
`endif
      default: Serial_Data_Out = 1'b0;
    endcase
  end

  always_comb begin
    state_next  = state;
    shift_next  = shift_reg;
    cnt_next    = bit_cnt;
`ifdef PISO_PARITY_EN
    parity_next = parity_acc;
`endif
    if (Enable_In) begin
      if (load_accept) begin
        // Also covers the final frame cycle, giving gap-free back-to-back frames.
        state_next  = SHIFT;
        shift_next  = Parallel_Data_In;
        cnt_next    = '0;
`ifdef PISO_PARITY_EN
        parity_next = ^Parallel_Data_In;
`endif
      end else begin
        case (state)
          SHIFT: begin
            if (bit_cnt == LAST_CNT) begin
`ifdef PISO_PARITY_EN
              // Counter parks at LAST_CNT through the parity cycle.
              state_next = PARITY;
`else
              state_next = IDLE;
              shift_next = '0;
              cnt_next   = '0;
`endif
            end else begin
              shift_next = shifted;
              cnt_next   = bit_cnt + CW'(1);
            end
          end
`ifdef PISO_PARITY_EN
          PARITY: begin
            state_next  = IDLE;
            shift_next  = '0;
            cnt_next    = '0;
            parity_next = 1'b0;
          end
`endif
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge Clk_In or negedge Reset_N_In) begin
    if (!Reset_N_In) begin
      state      <= IDLE;
      shift_reg  <= '0;
      bit_cnt    <= '0;
      rst_done   <= 1'b0;
`ifdef PISO_PARITY_EN
      parity_acc <= 1'b0;
`endif
    end else begin
      state      <= state_next;
      shift_reg  <= shift_next;
      bit_cnt    <= cnt_next;
      rst_done   <= 1'b1;
`ifdef PISO_PARITY_EN
      parity_acc <= parity_next;
`endif
    end
  end

endmodule

// File: tb/tb_parallel_in_serial_out_piso_param.sv
// tb/tb_parallel_in_serial_out_piso_param.sv - self-checking bench for the PISO serialiser
module tb_parallel_in_serial_out_piso_param;

  localparam int W = 8;
`ifdef PISO_PARITY_EN
  localparam int FL = W + 1;
`else
  localparam int FL = W;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         en;
  logic         lv;
  logic [W-1:0] pdata;
  logic rdy_m, sd_m, sv_m, fs_m, fd_m, bz_m;
  logic rdy_l, sd_l, sv_l, fs_l, fd_l, bz_l;

  always #5 clk = ~clk;

  parallel_in_serial_out_piso_param #(.DATA_WIDTH(W), .MSB_FIRST(1)) dut_msb (
    .Clk_In(clk), .Reset_N_In(rst_n), .Enable_In(en), .Load_Valid_In(lv),
    .Parallel_Data_In(pdata), .Load_Ready_Out(rdy_m), .Serial_Data_Out(sd_m),
    .Serial_Valid_Out(sv_m), .Frame_Start_Out(fs_m), .Frame_Done_Out(fd_m), .Busy_Out(bz_m)
  );

  parallel_in_serial_out_piso_param #(.DATA_WIDTH(W), .MSB_FIRST(0)) dut_lsb (
    .Clk_In(clk), .Reset_N_In(rst_n), .Enable_In(en), .Load_Valid_In(lv),
    .Parallel_Data_In(pdata), .Load_Ready_Out(rdy_l), .Serial_Data_Out(sd_l),
    .Serial_Valid_Out(sv_l), .Frame_Start_Out(fs_l), .Frame_Done_Out(fd_l), .Busy_Out(bz_l)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: a frame is a word plus a position within it.
  bit           m_busy;
  bit           m_rst_done;
  int           m_pos;
  logic [W-1:0] m_word;
  logic         exp_rdy;
  // Vector layout per DUT: {ready, data, valid, start, done, busy}; msb DUT first.
  logic [11:0]  obs, exp_v;

  function automatic logic frame_bit(logic [W-1:0] w, int pos, bit msb);
    if (pos >= W) return ^w;
    return msb ? w[W-1-pos] : w[pos];
  endfunction

  task automatic sample();
    obs = {rdy_m, sd_m, sv_m, fs_m, fd_m, bz_m, rdy_l, sd_l, sv_l, fs_l, fd_l, bz_l};
  endtask

  task automatic drive(bit e, bit v, logic [W-1:0] d);
    logic fin, vld, st, dn, bm, bl;
    en = e; lv = v; pdata = d;
    #1;
    fin     = m_busy && (m_pos == FL - 1);
    exp_rdy = e && m_rst_done && (!m_busy || fin);
    vld     = e && m_busy;
    st      = vld && (m_pos == 0);
    dn      = e && fin;
    bm      = m_busy ? frame_bit(m_word, m_pos, 1'b1) : 1'b0;
    bl      = m_busy ? frame_bit(m_word, m_pos, 1'b0) : 1'b0;
    exp_v   = {exp_rdy, bm, vld, st, dn, m_busy, exp_rdy, bl, vld, st, dn, m_busy};
    sample();
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) begin
      if (en) begin
        if (lv && exp_rdy) begin
          m_busy = 1'b1; m_pos = 0; m_word = pdata;
        end else if (m_busy) begin
          if (m_pos == FL - 1) m_busy = 1'b0;
          else m_pos++;
        end
      end
      m_rst_done = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; m_busy = 1'b0; m_rst_done = 1'b0; m_pos = 0; m_word = '0;
    drive(1'b1, 1'b1, 8'hFF);
    n_checks++; if (obs !== 12'h000) $display("FAIL reset_outputs got %b want %b", obs, 12'h000); else n_pass++;
    tick();
    rst_n = 1'b1;
    drive(1'b1, 1'b0, 8'h00);
    n_checks++; if (rdy_m !== 1'b0) $display("FAIL ready_before_first_edge got %b want 0", rdy_m); else n_pass++;
    tick();
    drive(1'b1, 1'b0, 8'h00);
    n_checks++; if (rdy_m !== 1'b1) $display("FAIL ready_after_first_edge got %b want 1", rdy_m); else n_pass++;
    n_checks++; if (obs !== exp_v) $display("FAIL reset_model got %b want %b", obs, exp_v); else n_pass++;
    tick();
  endtask

  task automatic test_frame_1e();
    logic [W-1:0] got_m, got_l;
    int nv;
    got_m = '0; got_l = '0; nv = 0;
    drive(1'b1, 1'b1, 8'h1E);
    n_checks++; if (obs !== exp_v) $display("FAIL frame_1e load got %b want %b", obs, exp_v); else n_pass++;
    tick();
    for (int c = 1; c <= FL + 1; c++) begin
      drive(1'b1, 1'b0, W'($urandom));
      n_checks++; if (obs !== exp_v) $display("FAIL frame_1e cycle %0d got %b want %b", c, obs, exp_v); else n_pass++;
      if (sv_m) begin
        if (nv < W) begin
          got_m = {got_m[W-2:0], sd_m};
          got_l = {got_l[W-2:0], sd_l};
        end
        nv++;
      end
      tick();
    end
    n_checks++; if (got_m !== 8'b00011110) $display("FAIL frame_1e_msb_bits got %b want 00011110", got_m); else n_pass++;
    n_checks++; if (got_l !== 8'b01111000) $display("FAIL frame_1e_lsb_bits got %b want 01111000", got_l); else n_pass++;
    n_checks++; if (nv !== FL) $display("FAIL frame_1e_valid_len got %0d want %0d", nv, FL); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int nv;
    int ready_bad;
    nv = 0; ready_bad = 0;
    drive(1'b1, 1'b1, 8'hA5);
    n_checks++; if (obs !== exp_v) $display("FAIL b2b load got %b want %b", obs, exp_v); else n_pass++;
    tick();
    for (int c = 1; c <= 2 * FL + 1; c++) begin
      drive(1'b1, c <= FL, (c == FL) ? 8'h3C : W'($urandom));
      n_checks++; if (obs !== exp_v) $display("FAIL b2b cycle %0d got %b want %b", c, obs, exp_v); else n_pass++;
      if (sv_m) nv++;
      if (c <= 2 * FL && (rdy_m !== ((c == FL) || (c == 2 * FL)))) ready_bad++;
      tick();
    end
    n_checks++; if (nv !== 2 * FL) $display("FAIL b2b_valid_len got %0d want %0d", nv, 2 * FL); else n_pass++;
    n_checks++; if (ready_bad !== 0) $display("FAIL b2b_ready_cycles got %0d bad want 0", ready_bad); else n_pass++;
  endtask

  task automatic test_enable_stall();
    int nv, stall_bad, done_cyc;
    bit e;
    nv = 0; stall_bad = 0; done_cyc = -1;
    drive(1'b1, 1'b1, 8'hF0);
    n_checks++; if (obs !== exp_v) $display("FAIL stall load got %b want %b", obs, exp_v); else n_pass++;
    tick();
    for (int c = 1; c <= FL + 4; c++) begin
      e = !(c >= 5 && c <= 7);
      drive(e, 1'b1, W'($urandom));
      n_checks++; if (obs !== exp_v) $display("FAIL stall cycle %0d got %b want %b", c, obs, exp_v); else n_pass++;
      if (sv_m) nv++;
      if (fd_m) done_cyc = c;
      if (!e && (sv_m || fs_m || fd_m || rdy_m || sv_l || fs_l || fd_l || rdy_l)) stall_bad++;
      // Stop offering words once the stalled frame has ended so the bench returns to idle.
      if (c == FL + 3) lv = 1'b0;
      tick();
    end
    lv = 1'b0;
    n_checks++; if (nv !== FL) $display("FAIL stall_valid_len got %0d want %0d", nv, FL); else n_pass++;
    n_checks++; if (stall_bad !== 0) $display("FAIL stall_quiet got %0d want 0", stall_bad); else n_pass++;
    n_checks++; if (done_cyc !== FL + 3) $display("FAIL stall_done_cycle got %0d want %0d", done_cyc, FL + 3); else n_pass++;
    // A new frame may have been accepted on the final cycle; drain it.
    for (int c = 0; c <= FL; c++) begin
      drive(1'b1, 1'b0, 8'h00);
      n_checks++; if (obs !== exp_v) $display("FAIL stall_drain cycle %0d got %b want %b", c, obs, exp_v); else n_pass++;
      tick();
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [W-1:0] got_m, got_l;
    int nv;
    got_m = '0; got_l = '0; nv = 0;
    drive(1'b1, 1'b1, 8'h5A);
    tick();
    for (int c = 1; c <= 6; c++) begin
      drive(1'b1, 1'b0, 8'h00);
      n_checks++; if (obs !== exp_v) $display("FAIL rst_mid cycle %0d got %b want %b", c, obs, exp_v); else n_pass++;
      if (c < 6) tick();
    end
    #1 rst_n = 1'b0;
    #1 sample();
    m_busy = 1'b0; m_rst_done = 1'b0; m_pos = 0;
    n_checks++; if (obs !== 12'h000) $display("FAIL rst_mid_async got %b want %b", obs, 12'h000); else n_pass++;
    tick();
    drive(1'b1, 1'b1, 8'h81);
    n_checks++; if (obs !== 12'h000) $display("FAIL rst_mid_held got %b want %b", obs, 12'h000); else n_pass++;
    tick();
    rst_n = 1'b1;
    drive(1'b1, 1'b1, 8'h81);
    n_checks++; if (obs !== exp_v) $display("FAIL rst_mid_release got %b want %b", obs, exp_v); else n_pass++;
    tick();
    drive(1'b1, 1'b1, 8'h81);
    n_checks++; if (obs !== exp_v) $display("FAIL rst_mid_reload got %b want %b", obs, exp_v); else n_pass++;
    tick();
    for (int c = 1; c <= FL + 1; c++) begin
      drive(1'b1, 1'b0, 8'h00);
      n_checks++; if (obs !== exp_v) $display("FAIL rst_mid_81 cycle %0d got %b want %b", c, obs, exp_v); else n_pass++;
      if (sv_m && nv < W) begin
        got_m = {got_m[W-2:0], sd_m};
        got_l = {got_l[W-2:0], sd_l};
      end
      if (sv_m) nv++;
      tick();
    end
    n_checks++; if (got_m !== 8'h81) $display("FAIL rst_mid_81_msb got %h want 81", got_m); else n_pass++;
    n_checks++; if (got_l !== 8'h81) $display("FAIL rst_mid_81_lsb got %h want 81", got_l); else n_pass++;
  endtask

`ifdef PISO_PARITY_EN
  task automatic test_parity();
    logic [W-1:0] words [2];
    logic         want  [2];
    words[0] = 8'h07; want[0] = 1'b1;
    words[1] = 8'h03; want[1] = 1'b0;
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, 1'b1, words[k]);
      tick();
      for (int c = 1; c <= FL; c++) begin
        drive(1'b1, 1'b0, 8'h00);
        n_checks++; if (obs !== exp_v) $display("FAIL parity cycle %0d got %b want %b", c, obs, exp_v); else n_pass++;
        if (c == FL) begin
          n_checks++;
          if (sd_m !== want[k] || fd_m !== 1'b1 || sv_m !== 1'b1)
            $display("FAIL parity_bit word %h got sd=%b done=%b valid=%b want sd=%b done=1 valid=1",
                     words[k], sd_m, fd_m, sv_m, want[k]);
          else n_pass++;
        end
        tick();
      end
    end
  endtask
`endif

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      drive(($urandom % 8) != 0, ($urandom % 3) != 0, W'($urandom));
      n_checks++; if (obs !== exp_v) $display("FAIL random cycle %0d got %b want %b", c, obs, exp_v); else n_pass++;
      tick();
    end
  endtask

  initial begin
    en = 1'b0; lv = 1'b0; pdata = '0; rst_n = 1'b0;
    test_reset();
    test_frame_1e();
    test_back_to_back();
    test_enable_stall();
    test_reset_mid_frame();
`ifdef PISO_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/parallel_in_serial_out_piso_param.md
PARALLEL_IN_SERIAL_OUT_PISO_PARAM -- requirements
Module: parallel_in_serial_out_piso_param

Interface
REQ-001 SHALL provide parameter DATA_WIDTH, default 32, meaning word width in bits; legal range >= 2.
REQ-002 SHALL provide parameter MSB_FIRST, default 1, meaning shift order (1 = MSB first, 0 = LSB first).
REQ-003 SHALL have one clock; reset is asynchronous and active-low.
REQ-004 SHALL provide Clk_In  input  1  sole clock, rising edge.
REQ-005 SHALL provide Reset_N_In  input  1  asynchronous active-low reset.
REQ-006 SHALL provide Enable_In  input  1  global advance qualifier; low freezes all state.
REQ-007 SHALL provide Load_Valid_In  input  1  a parallel word is offered.
REQ-008 SHALL provide Parallel_Data_In  input  DATA_WIDTH  word to serialise.
REQ-009 SHALL provide Load_Ready_Out  output  1  block accepts a word this cycle.
REQ-010 SHALL provide Serial_Data_Out  output  1  current serial bit.
REQ-011 SHALL provide Serial_Valid_Out  output  1  Serial_Data_Out carries a frame bit.
REQ-012 SHALL provide Frame_Start_Out  output  1  single-cycle strobe on the first bit of a frame.
REQ-013 SHALL provide Frame_Done_Out  output  1  single-cycle strobe on the last bit of a frame.
REQ-014 SHALL provide Busy_Out  output  1  high whenever state is not IDLE.

Function
REQ-015 SHALL implement states IDLE, SHIFT and PARITY; PARITY exists only under PISO_PARITY_EN.
REQ-016 SHALL accept a word at a rising edge only when Load_Valid_In, Load_Ready_Out and Enable_In are all high.
REQ-017 SHALL drive Load_Ready_Out = Enable_In AND (state IDLE OR on the final frame cycle).
REQ-018 SHALL, after acceptance at edge n, present frame bit 0 during cycle n+1 and bit k during cycle n+1+k, for DATA_WIDTH data bits.
REQ-019 SHALL send bit order Parallel_Data_In[DATA_WIDTH-1] down to [0] when MSB_FIRST=1, and [0] up to [DATA_WIDTH-1] when MSB_FIRST=0.
REQ-020 SHALL use a bit counter of $clog2(DATA_WIDTH) bits, reaching DATA_WIDTH-1 on the last data bit with no wrap beyond it.
REQ-021 SHALL assert Frame_Start_Out on bit 0 and Frame_Done_Out on the final frame cycle; the final frame cycle is the last data bit, or the parity cycle when parity is enabled.
REQ-022 SHALL, on acceptance during the final frame cycle, output bit 0 of the new word on the next cycle with no idle gap (back-to-back frames).
REQ-023 SHALL return to IDLE after the final frame cycle if no word is accepted.
REQ-024 SHALL, in IDLE, drive Serial_Data_Out=0, Serial_Valid_Out=0 and both strobes 0.
REQ-025 SHALL, while Enable_In is low, hold the shift register, counter and state, and force Serial_Valid_Out, Frame_Start_Out, Frame_Done_Out and Load_Ready_Out to 0. Serial_Data_Out holds its value.
REQ-026 SHALL ignore Parallel_Data_In and Load_Valid_In whenever Load_Ready_Out is low.

Reset
REQ-027 SHALL, when Reset_N_In goes low, immediately enter IDLE and clear the shift register, counter and parity accumulator, with Load_Ready_Out=0 and all other outputs 0; this applies mid-frame, aborting the frame.
REQ-028 SHALL, on the first edge after reset release, raise Load_Ready_Out if Enable_In is high.

Configuration
REQ-029 SHALL use macro PISO_PARITY_EN: when defined, append one even-parity bit (XOR of the data word) in a PARITY cycle after the last data bit; Serial_Valid_Out stays high during that cycle, and Frame_Done_Out moves to the parity cycle.
REQ-030 SHALL, without PISO_PARITY_EN, make frames exactly DATA_WIDTH cycles long with no parity logic.

Verification (DATA_WIDTH=8)
REQ-031 SHALL cover: MSB_FIRST=1, load 0x1E at edge n -> Serial_Data_Out 0,0,0,1,1,1,1,0 in cycles n+1..n+8, Start at n+1, Done at n+8, then IDLE.
REQ-032 SHALL cover: MSB_FIRST=0, load 0x1E -> serial 0,1,1,1,1,0,0,0; Serial_Valid_Out high for exactly 8 cycles.
REQ-033 SHALL cover: 0xA5 then 0x3C with Load_Valid_In held high -> 16 contiguous valid bits, and Load_Ready_Out high only on cycles 8 and 16.
REQ-034 SHALL cover: Enable_In low for 3 cycles after bit 3 of 0xF0 -> no valid bits and no strobes in those cycles, and the frame resumes at bit 4 with total length unchanged.
REQ-035 SHALL cover: Reset_N_In low mid-frame at bit 5 -> outputs 0 immediately, and the next load of 0x81 is serialised correctly from bit 0.
REQ-036 SHALL cover, with PISO_PARITY_EN: load 0x07 -> 8 data bits followed by parity 1 in cycle 9, Done at cycle 9; load 0x03 -> parity 0.
